// File: rtl/pll_reconfig_pkg.sv
// rtl/pll_reconfig_pkg.sv - shared types, status codes and sizing helper for the PLL reconfiguration master
package pll_reconfig_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    UPDATE,
    WAIT_DONE,
    PLL_RST,
    WAIT_LOCK,
    FINISH
  } state_e;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_SCAN_TO = 2'd1;
  localparam logic [1:0] ST_LOCK_TO = 2'd2;

  // Counter only ever compares against (limit - 1), so clog2 of the largest limit suffices.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_reconfig_if.sv
// rtl/pll_reconfig_if.sv - host-side request/result bundle of the PLL reconfiguration master
interface pll_reconfig_if #(
  parameter int SCAN_LEN = 144
);
  logic                start;
  logic [SCAN_LEN-1:0] cfg_data;
  logic                busy;
  logic                done;
  logic [1:0]          status;

  modport master (output start, cfg_data, input busy, done, status);
  modport slave  (input start, cfg_data, output busy, done, status);
endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchronizer with asynchronous active-low reset
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pll_reconfig_ctrl.sv
// rtl/pll_reconfig_ctrl.sv - scan-chain writer: shift image, strobe update, reset PLL, await lock
module pll_reconfig_ctrl
  import pll_reconfig_pkg::*;
#(
  parameter int SCAN_LEN      = 144,
  parameter int DONE_TIMEOUT  = 64,
  parameter int ARESET_CYCLES = 4,
  parameter int LOCK_TIMEOUT  = 1024
) (
  input  logic           clk,
  input  logic           areset_n,
  pll_reconfig_if.slave  host,
  input  logic           scandone,
  input  logic           locked,
  output logic           scandata,
  output logic           scanclkena,
  output logic           configupdate,
  output logic           pll_areset
);
  localparam int CW = cnt_width(SCAN_LEN, DONE_TIMEOUT, ARESET_CYCLES, LOCK_TIMEOUT);
  localparam logic [CW-1:0] SCAN_LAST   = CW'(SCAN_LEN - 1);
  localparam logic [CW-1:0] DONE_LAST   = CW'(DONE_TIMEOUT - 1);
  localparam logic [CW-1:0] ARESET_LAST = CW'(ARESET_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);

  state_e              state, state_nxt;
  logic [SCAN_LEN-1:0] shreg;
  logic [CW-1:0]       cnt;
  logic [1:0]          status_q;
  logic                lock_run;
  logic                locked_s;

  logic       load, shift_en, cnt_clr, cnt_inc, st_set, lock_set, lock_clr;
  logic [1:0] st_val;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (areset_n),
    .d     (locked),
    .q     (locked_s)
  );

  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    shift_en     = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    st_set       = 1'b0;
    st_val       = ST_OK;
    lock_set     = 1'b0;
    lock_clr     = 1'b0;
    scanclkena   = 1'b0;
    configupdate = 1'b0;
    pll_areset   = 1'b0;
    host.done    = 1'b0;
    case (state)
      IDLE: begin
        if (host.start) begin
          load      = 1'b1;
          cnt_clr   = 1'b1;
          st_set    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        scanclkena = 1'b1;
        shift_en   = 1'b1;
        cnt_inc    = 1'b1;
        if (cnt == SCAN_LAST) state_nxt = UPDATE;
      end
      UPDATE: begin
        configupdate = 1'b1;
        cnt_clr      = 1'b1;
        state_nxt    = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (scandone) begin
          cnt_clr   = 1'b1;
          state_nxt = PLL_RST;
        end else if (cnt == DONE_LAST) begin
          st_set    = 1'b1;
          st_val    = ST_SCAN_TO;
          state_nxt = FINISH;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      PLL_RST: begin
        pll_areset = 1'b1;
        if (cnt == ARESET_LAST) begin
          cnt_clr   = 1'b1;
          lock_clr  = 1'b1;
          state_nxt = WAIT_LOCK;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_LOCK: begin
        cnt_inc = 1'b1;
        // A second consecutive locked sample beats a timeout landing on the same cycle.
        if (locked_s && lock_run) begin
          st_set    = 1'b1;
          state_nxt = FINISH;
        end else begin
          lock_set = locked_s;
          lock_clr = !locked_s;
          if (cnt == LOCK_LAST) begin
            st_set    = 1'b1;
            st_val    = ST_LOCK_TO;
            state_nxt = FINISH;
          end
        end
      end
      FINISH: begin
        host.done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      status_q <= ST_OK;
      lock_run <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load)          shreg <= host.cfg_data;
      else if (shift_en) shreg <= {shreg[SCAN_LEN-2:0], 1'b0};
      if (cnt_clr)                      cnt <= '0;
      else if (cnt_inc && (cnt != '1))  cnt <= cnt + 1'b1;
      if (st_set)        status_q <= st_val;
      if (lock_clr)      lock_run <= 1'b0;
      else if (lock_set) lock_run <= 1'b1;
    end
  end

  assign scandata    = scanclkena & shreg[SCAN_LEN-1];
  assign host.busy   = (state != IDLE);
  assign host.status = status_q;

endmodule
